// File: rtl/gpio_irq_bank.sv
// gpio_irq_bank: register-mapped GPIO bank. Each set of pins has direction,
// output latch, a multi-flop input synchroniser and edge-detect interrupts
// with write-1-to-clear status, all merged onto a single level irq line.
module gpio_irq_bank #(
  parameter int NUM_GPIO_SETS = 4,
  parameter int GPIO_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [$clog2(NUM_GPIO_SETS)+2:0]       addr,
  input  logic                                   wr_en,
  input  logic                                   rd_en,
  input  logic [GPIO_WIDTH-1:0]                  wr_data,
  output logic [GPIO_WIDTH-1:0]                  rd_data,
  output logic                                   rd_valid,
  input  logic [NUM_GPIO_SETS*GPIO_WIDTH-1:0]    gpio_in,
  output logic [NUM_GPIO_SETS*GPIO_WIDTH-1:0]    gpio_out,
  output logic [NUM_GPIO_SETS*GPIO_WIDTH-1:0]    gpio_oe,
  output logic                                   irq
);

  localparam int SET_W  = $clog2(NUM_GPIO_SETS);
  localparam int ADDR_W = SET_W + 3;
  localparam int TOT_W  = NUM_GPIO_SETS * GPIO_WIDTH;
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

  logic [GPIO_WIDTH-1:0] r_dir    [NUM_GPIO_SETS];
  logic [GPIO_WIDTH-1:0] r_out    [NUM_GPIO_SETS];
  logic [GPIO_WIDTH-1:0] r_irq_en [NUM_GPIO_SETS];
  logic [GPIO_WIDTH-1:0] r_edge   [NUM_GPIO_SETS];
  logic [GPIO_WIDTH-1:0] r_status [NUM_GPIO_SETS];
  logic [TOT_W-1:0]      r_sync   [SYNC_STAGES];
  logic [TOT_W-1:0]      r_prev;
  logic [WARM_W-1:0]     r_warm;
  logic [GPIO_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_irq;

  logic [SET_W-1:0]      w_set;
  logic [2:0]            w_off;
  logic [TOT_W-1:0]      w_sync_in;
  logic [TOT_W-1:0]      w_rise;
  logic [TOT_W-1:0]      w_fall;
  logic [GPIO_WIDTH-1:0] w_w1c         [NUM_GPIO_SETS];
  logic [GPIO_WIDTH-1:0] w_event       [NUM_GPIO_SETS];
  logic [GPIO_WIDTH-1:0] w_next_status [NUM_GPIO_SETS];
  logic [GPIO_WIDTH-1:0] w_rd_mux;
  logic                  w_irq_next;

  assign w_set     = addr[ADDR_W-1:3];
  assign w_off     = addr[2:0];
  assign w_sync_in = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_sync_in & ~r_prev;
  assign w_fall    = ~w_sync_in & r_prev;

  // Per-set edge events, status next-state, irq merge and read-data mux.
  // Unmapped set indices match no set, so they read 0 and ignore writes.
  always_comb begin
    w_rd_mux   = '0;
    w_irq_next = 1'b0;
    for (int s = 0; s < NUM_GPIO_SETS; s++) begin
      w_w1c[s] = (wr_en && (w_set == SET_W'(s)) && (w_off == 3'd4)) ? wr_data : '0;
      w_event[s] = '0;
      if (r_warm == '0) begin
        w_event[s] = ~r_dir[s] &
                     ((r_edge[s] & w_rise[s*GPIO_WIDTH +: GPIO_WIDTH]) |
                      (~r_edge[s] & w_fall[s*GPIO_WIDTH +: GPIO_WIDTH]));
      end
      // A clear and a new event on the same bit: the event wins.
      w_next_status[s] = (r_status[s] & ~w_w1c[s]) | w_event[s];
      w_irq_next = w_irq_next | (|(w_next_status[s] & r_irq_en[s]));
      if (w_set == SET_W'(s)) begin
        case (w_off)
          3'd0:    w_rd_mux = r_dir[s];
          3'd1:    w_rd_mux = (r_dir[s] & r_out[s]) |
                              (~r_dir[s] & w_sync_in[s*GPIO_WIDTH +: GPIO_WIDTH]);
          3'd2:    w_rd_mux = r_irq_en[s];
          3'd3:    w_rd_mux = r_edge[s];
          3'd4:    w_rd_mux = r_status[s];
          default: w_rd_mux = '0;
        endcase
      end
    end
  end

  // Configuration registers, output latch and interrupt status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_GPIO_SETS; s++) begin
        r_dir[s]    <= '0;
        r_out[s]    <= '0;
        r_irq_en[s] <= '0;
        r_edge[s]   <= '0;
        r_status[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_GPIO_SETS; s++) begin
        r_status[s] <= w_next_status[s];
        if (wr_en && (w_set == SET_W'(s))) begin
          case (w_off)
            3'd0:    r_dir[s]    <= wr_data;
            3'd1:    r_out[s]    <= wr_data;
            3'd2:    r_irq_en[s] <= wr_data;
            3'd3:    r_edge[s]   <= wr_data;
            default: ;
          endcase
        end
      end
    end
  end

  // Input synchroniser, previous-sample register and post-reset warm-up
  // counter that masks the edges produced while the chain fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
      r_warm <= WARM_INIT;
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync_in;
      if (r_warm != '0) r_warm <= r_warm - 1'b1;
    end
  end

  // Registered read port (data held between reads) and interrupt line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
      r_irq <= w_irq_next;
    end
  end

  for (genvar s = 0; s < NUM_GPIO_SETS; s++) begin : g_pads
    assign gpio_out[s*GPIO_WIDTH +: GPIO_WIDTH] = r_out[s];
    assign gpio_oe[s*GPIO_WIDTH +: GPIO_WIDTH]  = r_dir[s];
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign irq      = r_irq;

endmodule
